seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_pkg.sv | 16 +
 rtl/seq_match_core.sv | 51 +++++
 rtl/seq_detect_ctrl.sv | 133 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned PAT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked comparator; match_o is
// combinational on the post-shift history so the parent can register it.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     shift_i,
  input  logic                     data_i,
  input  logic [PAT_W-1:0]         pattern_i,
  input  logic [$clog2(PAT_W)-1:0] len_i,
  input  logic                     overlap_i,
  output logic                     match_o
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d, mask;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], data_i};
    fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i <= int'(len_i));
    end
  end

  assign match_o = shift_i
                && (fill_d >= FILL_W'(len_i) + FILL_W'(1))
                && (((hist_d ^ pattern_i) & mask) == '0);

  // Non-overlapping mode restarts the fill so a new match needs a fresh window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_d;
      fill_q <= (match_o && !overlap_i) ? '0 : fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-controlled serial pattern detector with match counting and limit.
// Optional idle timeout enabled by defining SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset, config writable, waiting for start
// RUN     | shifting data, counting matches
// DONE    | run ended (stop/limit/timeout), results held, config writable
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W       = PAT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_W)-1:0] cfg_len,
  input  logic                     cfg_overlap,
  input  logic [7:0]               cfg_limit,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     data,
  input  logic                     data_vld,
  output logic                     flag,
  output logic [7:0]               match_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout
);

  seq_state_e               state_q;
  logic [PAT_W-1:0]         cfg_pattern_q;
  logic [$clog2(PAT_W)-1:0] cfg_len_q;
  logic                     cfg_overlap_q;
  logic [7:0]               cfg_limit_q;
  logic                     flag_q;
  logic [7:0]               match_cnt_q, match_cnt_d;
  logic                     run_start, shift_en, match, limit_hit;

  assign run_start   = (state_q != ST_RUN) && start;
  assign shift_en    = (state_q == ST_RUN) && data_vld;
  assign match_cnt_d = sat_inc8(match_cnt_q);
  assign limit_hit   = match && (cfg_limit_q != 8'd0) && (match_cnt_d == cfg_limit_q);

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (run_start),
    .shift_i   (shift_en),
    .data_i    (data),
    .pattern_i (cfg_pattern_q),
    .len_i     (cfg_len_q),
    .overlap_i (cfg_overlap_q),
    .match_o   (match)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             timeout_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cfg_pattern_q <= '0;
      cfg_len_q     <= '0;
      cfg_overlap_q <= 1'b1;
      cfg_limit_q   <= '0;
      flag_q        <= 1'b0;
      match_cnt_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmr_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      flag_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_we) begin
            cfg_pattern_q <= cfg_pattern;
            cfg_len_q     <= cfg_len;
            cfg_overlap_q <= cfg_overlap;
            cfg_limit_q   <= cfg_limit;
          end
          if (start) begin
            state_q     <= ST_RUN;
            match_cnt_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            tmr_q       <= TMR_W'(TIMEOUT_CYC - 1);
            timeout_q   <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          // A match in the stop cycle is still counted and flagged.
          if (match) begin
            flag_q      <= 1'b1;
            match_cnt_q <= match_cnt_d;
          end
          if (stop || limit_hit) begin
            state_q <= ST_DONE;
          end
`ifdef SEQ_TIMEOUT_EN
          if (match) begin
            tmr_q <= TMR_W'(TIMEOUT_CYC - 1);
          end else if (tmr_q == '0) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flag      = flag_q;
  assign match_cnt = match_cnt_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

`ifdef SEQ_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // No timer in this build; the parameter stays so both builds share one interface.
  assign timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       start, stop, data, data_vld;
  logic       flag, busy, done, timeout;
  logic [7:0] match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.PAT_W(8), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
    .start       (start),
    .stop        (stop),
    .data        (data),
    .data_vld    (data_vld),
    .flag        (flag),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [2:0] len,
                           input logic ovl, input logic [7:0] lim);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_limit   = lim;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Bits are sent MSB first; flags collects the flag seen after each bit, MSB first.
  task automatic send_bits(input logic [15:0] bits, input int n, output logic [15:0] flags);
    flags = '0;
    for (int i = n - 1; i >= 0; i--) begin
      data     = bits[i];
      data_vld = 1'b1;
      tick();
      data_vld = 1'b0;
      flags    = {flags[14:0], flag};
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("gap_no_flag", flag, 1'b0);
    end
  endtask

  logic [15:0] fl;
  int          n;

  initial begin
    rst = 1'b0;
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_limit = '0;
    start = 1'b0; stop = 1'b0; data = 1'b0; data_vld = 1'b0;
    repeat (3) tick();
    chk("rst_flag", flag, 1'b0);
    chk("rst_cnt", match_cnt, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Overlapping 1011 over 1011011
    cfg_write(8'b0000_1011, 3'd3, 1'b1, 8'd0);
    pulse_start();
    chk("ovl_busy", busy, 1'b1);
    send_bits(16'b1011011, 7, fl);
    chk("ovl_flags", fl[6:0], 7'b0001001);
    chk("ovl_cnt", match_cnt, 8'd2);
    pulse_stop();
    chk("ovl_done", done, 1'b1);
    chk("ovl_hold_cnt", match_cnt, 8'd2);

    // Non-overlapping, same stream
    cfg_write(8'b0000_1011, 3'd3, 1'b0, 8'd0);
    pulse_start();
    chk("novl_cnt_clr", match_cnt, 8'd0);
    send_bits(16'b1011011, 7, fl);
    chk("novl_flags", fl[6:0], 7'b0001000);
    chk("novl_cnt", match_cnt, 8'd1);
    pulse_stop();

    // Limit 3, single-bit pattern
    cfg_write(8'b0000_0001, 3'd0, 1'b1, 8'd3);
    pulse_start();
    send_bits(16'b111, 3, fl);
    chk("lim_flags", fl[2:0], 3'b111);
    chk("lim_done_on_third", done, 1'b1);
    send_bits(16'b11, 2, fl);
    chk("lim_after_flags", fl[1:0], 2'b00);
    chk("lim_cnt", match_cnt, 8'd3);
    chk("lim_done_hold", done, 1'b1);

    // Fill gating with an all-zero pattern, non-overlapping
    cfg_write(8'h00, 3'd3, 1'b0, 8'd0);
    pulse_start();
    send_bits(16'b0000_0000, 8, fl);
    chk("fill_flags", fl[7:0], 8'b0001_0001);
    chk("fill_cnt", match_cnt, 8'd2);
    pulse_stop();

    // data_vld gaps inside 1011
    cfg_write(8'b0000_1011, 3'd3, 1'b1, 8'd0);
    pulse_start();
    send_bits(16'b1, 1, fl);
    idle_gap(2);
    send_bits(16'b0, 1, fl);
    idle_gap(1);
    send_bits(16'b1, 1, fl);
    idle_gap(3);
    send_bits(16'b1, 1, fl);
    chk("gap_match_flag", fl[0], 1'b1);
    tick();
    chk("gap_flag_one_cycle", flag, 1'b0);
    chk("gap_cnt", match_cnt, 8'd1);

    // cfg_we in RUN ignored (new config would flag on a 0 and stop at limit 1)
    cfg_write(8'h00, 3'd0, 1'b1, 8'd1);
    chk("cfgrun_busy", busy, 1'b1);
    send_bits(16'b1011, 4, fl);
    chk("cfgrun_flags", fl[3:0], 4'b0001);
    chk("cfgrun_cnt", match_cnt, 8'd2);
    chk("cfgrun_still_busy", busy, 1'b1);

    // stop together with a matching bit
    send_bits(16'b01, 2, fl);
    chk("stopm_pre_flags", fl[1:0], 2'b00);
    data = 1'b1; data_vld = 1'b1; stop = 1'b1;
    tick();
    data_vld = 1'b0; stop = 1'b0;
    chk("stopm_flag", flag, 1'b1);
    chk("stopm_cnt", match_cnt, 8'd3);
    chk("stopm_done", done, 1'b1);

    // start+stop together in RUN behaves as stop
    pulse_start();
    chk("ss_busy", busy, 1'b1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_done", done, 1'b1);
    chk("ss_cnt", match_cnt, 8'd0);

    // Reset mid-run on the cycle a match would be sampled
    cfg_write(8'b0000_1011, 3'd3, 1'b1, 8'd0);
    pulse_start();
    send_bits(16'b101101, 6, fl);
    chk("rr_flags", fl[5:0], 6'b000100);
    chk("rr_cnt_pre", match_cnt, 8'd1);
    data = 1'b1; data_vld = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rr_async_cnt", match_cnt, 8'd0);
    chk("rr_async_busy", busy, 1'b0);
    chk("rr_async_flag", flag, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    data_vld = 1'b0;
    tick();
    chk("rr_flag", flag, 1'b0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_done", done, 1'b0);
    chk("rr_timeout", timeout, 1'b0);

    // Config reset values: pattern 0, len 0, overlap 1, limit 0
    pulse_start();
    send_bits(16'b01, 2, fl);
    chk("cfgrst_flags", fl[1:0], 2'b10);
    chk("cfgrst_cnt", match_cnt, 8'd1);
    chk("cfgrst_busy", busy, 1'b1);
    pulse_stop();

    // Idle run without matches
    cfg_write(8'hFF, 3'd7, 1'b1, 8'd0);
    pulse_start();
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
`ifdef SEQ_TIMEOUT_EN
    chk("tmo_cycles", n, 16);
    chk("tmo_flag", timeout, 1'b1);
    chk("tmo_done", done, 1'b1);
    pulse_start();
    chk("tmo_clear", timeout, 1'b0);
    pulse_stop();
`else
    chk("notmo_done", done, 1'b0);
    chk("notmo_timeout", timeout, 1'b0);
    chk("notmo_busy", busy, 1'b1);
    pulse_stop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
